// File: rtl/alu_seq.sv
// alu_seq: multi-cycle, width-parametrised 6502-style ALU with an optional
// decimal-adjust stage and a start/done handshake.
// With BCD_EN=1, WIDTH must be a multiple of 4 (one BCD digit per nibble).
module alu_seq #(
   parameter int WIDTH     = 8,
   parameter int OPP_WIDTH = 4,
   parameter bit BCD_EN    = 1'b1
) (
   input  logic                 phi1,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [OPP_WIDTH-1:0] func,
   input  logic [7:0]           status_in,
   input  logic                 dec_mode,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     dout,
   output logic [7:0]           status_out,
   output logic                 wout,
   output logic                 wout_status,
   output logic                 err
);

   localparam logic [OPP_WIDTH-1:0] OP_SUM = OPP_WIDTH'(0);
   localparam logic [OPP_WIDTH-1:0] OP_SUB = OPP_WIDTH'(1);
   localparam logic [OPP_WIDTH-1:0] OP_AND = OPP_WIDTH'(2);
   localparam logic [OPP_WIDTH-1:0] OP_OR  = OPP_WIDTH'(3);
   localparam logic [OPP_WIDTH-1:0] OP_XOR = OPP_WIDTH'(4);
   localparam logic [OPP_WIDTH-1:0] OP_ASL = OPP_WIDTH'(5);
   localparam logic [OPP_WIDTH-1:0] OP_LSR = OPP_WIDTH'(6);
   localparam logic [OPP_WIDTH-1:0] OP_ROL = OPP_WIDTH'(7);
   localparam logic [OPP_WIDTH-1:0] OP_ROR = OPP_WIDTH'(8);
   localparam logic [OPP_WIDTH-1:0] OP_INC = OPP_WIDTH'(9);
   localparam logic [OPP_WIDTH-1:0] OP_DEC = OPP_WIDTH'(10);
   localparam logic [OPP_WIDTH-1:0] OP_CMP = OPP_WIDTH'(11);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_ADJ  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state_r;
   logic [WIDTH-1:0]       a_r, b_r, dout_r;
   logic [OPP_WIDTH-1:0]   func_r;
   logic [7:0]             st_r, status_r;
   logic                   dec_r, busy_r, done_r, wout_r, wout_status_r, err_r;

   logic [WIDTH-1:0]       b_eff_s, res_s;
   logic [WIDTH:0]         sum_s, diff_s, bcd_s;
   logic [7:0]             flags_s;
   logic                   c_s, v_s, wr_s, wrs_s, err_s, adj_s;

   // Decimal add: nibble-serial ripple, returns {carry, result}.
   function automatic logic [WIDTH:0] bcd_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic cin);
      logic [WIDTH-1:0] r;
      logic [4:0]       s;
      logic             c;
      r = '0;
      c = cin;
      for (int i = 0; i < WIDTH / 4; i++) begin
         s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0000, c};
         if (s > 5'd9) begin
            r[4*i +: 4] = s[3:0] + 4'd6;
            c = 1'b1;
         end else begin
            r[4*i +: 4] = s[3:0];
            c = 1'b0;
         end
      end
      return {c, r};
   endfunction

   // Decimal subtract: borrow enters as ~cin, carry leaves as ~borrow.
   function automatic logic [WIDTH:0] bcd_sub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic cin);
      logic [WIDTH-1:0] r;
      logic [5:0]       s;
      logic             w;
      r = '0;
      w = ~cin;
      for (int i = 0; i < WIDTH / 4; i++) begin
         s = {2'b00, x[4*i +: 4]} - {2'b00, y[4*i +: 4]} - {5'b00000, w};
         if (s[5]) begin
            r[4*i +: 4] = s[3:0] + 4'd10;
            w = 1'b1;
         end else begin
            r[4*i +: 4] = s[3:0];
            w = 1'b0;
         end
      end
      return {~w, r};
   endfunction

   // Binary result, flags and write strobes from the latched operands.
   always_comb begin
      b_eff_s = (func_r == OP_SUB) ? ~b_r : b_r;
      sum_s   = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, st_r[0]};
      diff_s  = {1'b0, a_r} + {1'b0, ~b_r} + (WIDTH+1)'(1);
      res_s   = '0;
      c_s     = st_r[0];
      v_s     = st_r[6];
      wr_s    = 1'b1;
      wrs_s   = 1'b1;
      err_s   = 1'b0;
      case (func_r)
         OP_SUM, OP_SUB: begin
            res_s = sum_s[WIDTH-1:0];
            c_s   = sum_s[WIDTH];
            v_s   = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
         end
         OP_AND: res_s = a_r & b_r;
         OP_OR:  res_s = a_r | b_r;
         OP_XOR: res_s = a_r ^ b_r;
         OP_ASL: begin res_s = {a_r[WIDTH-2:0], 1'b0};     c_s = a_r[WIDTH-1]; end
         OP_LSR: begin res_s = {1'b0, a_r[WIDTH-1:1]};     c_s = a_r[0];       end
         OP_ROL: begin res_s = {a_r[WIDTH-2:0], st_r[0]};  c_s = a_r[WIDTH-1]; end
         OP_ROR: begin res_s = {st_r[0], a_r[WIDTH-1:1]};  c_s = a_r[0];       end
         OP_INC: res_s = a_r + WIDTH'(1);
         OP_DEC: res_s = a_r - WIDTH'(1);
         OP_CMP: begin
            res_s = diff_s[WIDTH-1:0];
            c_s   = diff_s[WIDTH];
            wr_s  = 1'b0;
         end
         default: begin
            err_s = 1'b1;
            wr_s  = 1'b0;
            wrs_s = 1'b0;
         end
      endcase
      flags_s    = st_r;
      flags_s[0] = c_s;
      flags_s[1] = (res_s == '0);
      flags_s[6] = v_s;
      flags_s[7] = res_s[WIDTH-1];
      bcd_s      = (func_r == OP_SUB) ? bcd_sub(a_r, b_r, st_r[0]) : bcd_add(a_r, b_r, st_r[0]);
      adj_s      = BCD_EN && dec_r && ((func_r == OP_SUM) || (func_r == OP_SUB));
   end

   // Sequencer: operand capture, result/flag registers and handshake pulses.
   always_ff @(posedge phi1) begin
      if (reset) begin
         state_r       <= S_IDLE;
         a_r           <= '0;
         b_r           <= '0;
         func_r        <= '0;
         st_r          <= 8'h00;
         dec_r         <= 1'b0;
         dout_r        <= '0;
         status_r      <= 8'h00;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         wout_r        <= 1'b0;
         wout_status_r <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         done_r        <= 1'b0;
         wout_r        <= 1'b0;
         wout_status_r <= 1'b0;
         err_r         <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  func_r  <= func;
                  st_r    <= status_in;
                  dec_r   <= dec_mode;
                  busy_r  <= 1'b1;
                  state_r <= S_EXEC;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_EXEC: begin
               if (adj_s) begin
                  state_r <= S_ADJ;
               end else begin
                  if (wr_s) dout_r <= res_s;
                  if (wrs_s) status_r <= flags_s;
                  done_r        <= 1'b1;
                  wout_r        <= wr_s;
                  wout_status_r <= wrs_s;
                  err_r         <= err_s;
                  busy_r        <= 1'b0;
                  state_r       <= S_DONE;
               end
            end
            S_ADJ: begin
               // N, Z and V keep the binary-path values; only C is decimal.
               dout_r        <= bcd_s[WIDTH-1:0];
               status_r      <= {flags_s[7:1], bcd_s[WIDTH]};
               done_r        <= 1'b1;
               wout_r        <= 1'b1;
               wout_status_r <= 1'b1;
               busy_r        <= 1'b0;
               state_r       <= S_DONE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign dout        = dout_r;
   assign status_out  = status_r;
   assign wout        = wout_r;
   assign wout_status = wout_status_r;
   assign err         = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: 8-bit instance driven through a scoreboard
// with an independent arithmetic model, plus a 16-bit instance for width checks.
module tb_alu_seq;

   logic        phi1, reset;
   logic        start, dec_mode, busy, done, wout, wout_status, err;
   logic [7:0]  a, b, status_in, dout, status_out;
   logic [3:0]  func;

   logic        start16, dec16, busy16, done16, wout16, wstat16, err16;
   logic [15:0] a16, b16, dout16;
   logic [7:0]  st16, status16;
   logic [3:0]  func16;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] st;
      logic       w;
      logic       ws;
      logic       e;
      logic [3:0] lat;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] mdl_d  = 8'h00;
   logic [7:0] mdl_st = 8'h00;

   alu_seq #(.WIDTH(8), .OPP_WIDTH(4), .BCD_EN(1'b1)) dut8 (
      .phi1(phi1), .reset(reset), .start(start), .a(a), .b(b), .func(func),
      .status_in(status_in), .dec_mode(dec_mode), .busy(busy), .done(done),
      .dout(dout), .status_out(status_out), .wout(wout),
      .wout_status(wout_status), .err(err)
   );

   alu_seq #(.WIDTH(16), .OPP_WIDTH(4), .BCD_EN(1'b1)) dut16 (
      .phi1(phi1), .reset(reset), .start(start16), .a(a16), .b(b16), .func(func16),
      .status_in(st16), .dec_mode(dec16), .busy(busy16), .done(done16),
      .dout(dout16), .status_out(status16), .wout(wout16),
      .wout_status(wstat16), .err(err16)
   );

   initial phi1 = 1'b0;
   always #5 phi1 = ~phi1;

   // Reference model of one 8-bit operation (pd/pst: currently held outputs).
   function automatic exp_t model(input logic [7:0] oa, input logic [7:0] ob,
                                  input logic [3:0] f, input logic [7:0] st,
                                  input logic dec, input logic [7:0] pd,
                                  input logic [7:0] pst);
      exp_t e;
      logic [7:0] res, dval;
      logic c, v;
      int r, bb, lo, hi, cin, k;
      cin = int'(st[0]);
      c = st[0]; v = st[6]; res = 8'h00; dval = 8'h00;
      e.w = 1'b1; e.ws = 1'b1; e.e = 1'b0; e.lat = 4'd2;
      case (f)
         4'd0, 4'd1: begin
            bb = (f == 4'd1) ? 255 - int'(ob) : int'(ob);
            r = int'(oa) + bb + cin;
            res = r[7:0]; dval = res; c = (r > 255);
            v = (((int'(oa) ^ r) & (bb ^ r) & 128) != 0);
            if (dec) begin
               e.lat = 4'd3;
               if (f == 4'd0) begin
                  lo = int'(oa[3:0]) + int'(ob[3:0]) + cin;
                  k = (lo > 9) ? 1 : 0;
                  if (k == 1) lo = (lo + 6) & 15;
                  hi = int'(oa[7:4]) + int'(ob[7:4]) + k;
                  c = (hi > 9);
                  if (c) hi = (hi + 6) & 15;
               end else begin
                  lo = int'(oa[3:0]) - int'(ob[3:0]) - (1 - cin);
                  k = (lo < 0) ? 1 : 0;
                  if (k == 1) lo = (lo + 10) & 15;
                  hi = int'(oa[7:4]) - int'(ob[7:4]) - k;
                  c = !(hi < 0);
                  if (!c) hi = (hi + 10) & 15;
               end
               dval = 8'((hi << 4) | lo);
            end
         end
         4'd2:  begin res = oa & ob; dval = res; end
         4'd3:  begin res = oa | ob; dval = res; end
         4'd4:  begin res = oa ^ ob; dval = res; end
         4'd5:  begin res = {oa[6:0], 1'b0};  c = oa[7]; dval = res; end
         4'd6:  begin res = {1'b0, oa[7:1]};  c = oa[0]; dval = res; end
         4'd7:  begin res = {oa[6:0], st[0]}; c = oa[7]; dval = res; end
         4'd8:  begin res = {st[0], oa[7:1]}; c = oa[0]; dval = res; end
         4'd9:  begin res = oa + 8'd1; dval = res; end
         4'd10: begin res = oa - 8'd1; dval = res; end
         4'd11: begin res = oa - ob; c = (oa >= ob); dval = pd; e.w = 1'b0; end
         default: begin dval = pd; e.w = 1'b0; e.ws = 1'b0; e.e = 1'b1; end
      endcase
      e.d = dval;
      if (e.ws) e.st = {res[7], v, st[5:2], (res == 8'h00), c};
      else e.st = pst;
      return e;
   endfunction

   // Issue one op, wait (bounded) for done, compare against the scoreboard.
   task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                         input logic [7:0] ost, input logic odec, input bit b2b,
                         input bit poke, input string nm);
      exp_t e;
      int k;
      e = model(oa, ob, f, ost, odec, mdl_d, mdl_st);
      sbq.push_back(e);
      mdl_d = e.d; mdl_st = e.st;
      if (!b2b) @(negedge phi1);
      a = oa; b = ob; func = f; status_in = ost; dec_mode = odec; start = 1'b1;
      @(negedge phi1);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); func = 4'($urandom);
      status_in = 8'($urandom); dec_mode = 1'($urandom);
      k = 1;
      while (done !== 1'b1 && k < 8) begin
         tests++;
         if (busy !== 1'b1) begin fails++; $display("FAIL %s busy cycle %0d: got %b want 1", nm, k, busy); end
         if (poke && k == 1) begin start = 1'b1; func = 4'd9; end
         @(negedge phi1);
         start = 1'b0;
         k++;
      end
      e = sbq.pop_front();
      tests++;
      if (k !== int'(e.lat)) begin fails++; $display("FAIL %s latency: got %0d want %0d", nm, k, e.lat); end
      tests++;
      if (dout !== e.d) begin fails++; $display("FAIL %s dout: got %h want %h", nm, dout, e.d); end
      tests++;
      if (status_out !== e.st) begin fails++; $display("FAIL %s status: got %h want %h", nm, status_out, e.st); end
      tests++;
      if ({wout, wout_status, err} !== {e.w, e.ws, e.e}) begin
         fails++; $display("FAIL %s w/ws/err: got %b%b%b want %b%b%b", nm, wout, wout_status, err, e.w, e.ws, e.e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start16 = 1'b0;
      repeat (2) @(negedge phi1);
      tests++;
      if ({busy, done, dout, status_out, wout, wout_status, err} !== 21'd0) begin
         fails++; $display("FAIL reset8: got dout=%h st=%h busy=%b done=%b want all 0", dout, status_out, busy, done);
      end
      tests++;
      if ({busy16, done16, dout16, status16, wout16, wstat16, err16} !== 29'd0) begin
         fails++; $display("FAIL reset16: got dout=%h st=%h want all 0", dout16, status16);
      end
      reset = 1'b0;
      mdl_d = 8'h00; mdl_st = 8'h00;
   endtask

   task automatic test_plan_ops();
      run_op(8'h50, 8'h50, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "sum_bin");
      run_op(8'h58, 8'h46, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0, "sum_dec");
      run_op(8'h12, 8'h21, 4'd1, 8'h01, 1'b1, 1'b0, 1'b0, "sub_dec");
      run_op(8'h01, 8'h00, 4'd8, 8'h01, 1'b0, 1'b0, 1'b0, "ror");
      tests++;
      if (dout !== 8'h80 || status_out[0] !== 1'b1 || status_out[7] !== 1'b1) begin
         fails++; $display("FAIL ror_const: got dout=%h st=%h want 80 with N,C", dout, status_out);
      end
      run_op(8'h10, 8'h10, 4'd11, 8'h00, 1'b0, 1'b0, 1'b0, "cmp_eq");
      tests++;
      if (dout !== 8'h80 || status_out[1:0] !== 2'b11) begin
         fails++; $display("FAIL cmp_const: got dout=%h st=%h want 80 with Z,C", dout, status_out);
      end
      run_op(8'h33, 8'h44, 4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, "unknown");
   endtask

   task automatic test_all_ops();
      for (int f = 2; f <= 14; f++)
         run_op(8'($urandom), 8'($urandom), 4'(f), 8'($urandom), 1'($urandom), 1'b0, 1'b0, "op_sweep");
      for (int i = 0; i < 8; i++)
         run_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'b0, 1'b0, "arith_rand");
      run_op(8'h00, 8'h01, 4'd1, 8'h01, 1'b0, 1'b0, 1'b0, "sub_borrow");
      run_op(8'hFF, 8'h00, 4'd9, 8'h00, 1'b0, 1'b0, 1'b0, "inc_wrap");
      run_op(8'h00, 8'h00, 4'd10, 8'h00, 1'b0, 1'b0, 1'b0, "dec_wrap");
      run_op(8'h99, 8'h01, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, "dec_99p1");
   endtask

   task automatic test_start_while_busy();
      run_op(8'h21, 8'h13, 4'd2, 8'h00, 1'b0, 1'b0, 1'b1, "busy_poke");
      for (int i = 0; i < 2; i++) begin
         @(negedge phi1);
         tests++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL busy_ignore: got busy=%b done=%b want 0 0", busy, done);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_op(8'h0F, 8'h01, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "b2b_first");
      run_op(8'h40, 8'h00, 4'd5, 8'h00, 1'b0, 1'b1, 1'b0, "b2b_second");
      run_op(8'h09, 8'h01, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, "b2b_third");
   endtask

   task automatic test_reset_mid_op();
      @(negedge phi1);
      a = 8'h77; b = 8'h11; func = 4'd0; status_in = 8'h00; dec_mode = 1'b0; start = 1'b1;
      @(negedge phi1);
      start = 1'b0; reset = 1'b1;
      @(negedge phi1);
      reset = 1'b0;
      tests++;
      if ({busy, done, dout, status_out, wout, wout_status, err} !== 21'd0) begin
         fails++; $display("FAIL reset_mid: got dout=%h st=%h busy=%b done=%b want all 0", dout, status_out, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge phi1);
         tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_mid_idle: got done=%b busy=%b want 0 0", done, busy);
         end
      end
      mdl_d = 8'h00; mdl_st = 8'h00;
   endtask

   task automatic test_width16();
      logic [15:0] ea [2];
      logic [15:0] eb [2];
      logic [15:0] ed [2];
      logic [7:0]  es [2];
      int          el [2];
      int          k;
      ea[0] = 16'hFFFF; eb[0] = 16'h0001; ed[0] = 16'h0000; es[0] = 8'h03; el[0] = 2;
      ea[1] = 16'h9999; eb[1] = 16'h0001; ed[1] = 16'h0000; es[1] = 8'h81; el[1] = 3;
      for (int i = 0; i < 2; i++) begin
         @(negedge phi1);
         a16 = ea[i]; b16 = eb[i]; func16 = 4'd0; st16 = 8'h00; dec16 = (i == 1); start16 = 1'b1;
         @(negedge phi1);
         start16 = 1'b0;
         k = 1;
         while (done16 !== 1'b1 && k < 8) begin
            @(negedge phi1);
            k++;
         end
         tests++;
         if (k !== el[i]) begin fails++; $display("FAIL w16_lat%0d: got %0d want %0d", i, k, el[i]); end
         tests++;
         if (dout16 !== ed[i]) begin fails++; $display("FAIL w16_dout%0d: got %h want %h", i, dout16, ed[i]); end
         tests++;
         if (status16 !== es[i]) begin fails++; $display("FAIL w16_st%0d: got %h want %h", i, status16, es[i]); end
         tests++;
         if (wout16 !== 1'b1 || wstat16 !== 1'b1) begin
            fails++; $display("FAIL w16_wr%0d: got %b%b want 11", i, wout16, wstat16);
         end
      end
   endtask

   initial begin
      start = 1'b0; a = 8'h00; b = 8'h00; func = 4'd0; status_in = 8'h00; dec_mode = 1'b0;
      start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; func16 = 4'd0; st16 = 8'h00; dec16 = 1'b0;
      reset = 1'b1;
      test_reset();
      test_plan_ops();
      test_all_ops();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      test_width16();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
